// File: rtl/hft_result_tx.sv
// Result transmit path: buffers core decision frames on ap_done and streams them as 32-bit words.
// Optional macro HFT_TX_SEQ_EN prefixes each frame with a capture-time sequence number.
module hft_result_tx #(
    parameter int FRAME_DEPTH = 4,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  res_done,
    input  logic [1:0]            res_action,
    input  logic [31:0]           res_price,
    input  logic [31:0]           res_quantity,
    input  logic                  res_idle,
    input  logic                  res_ready,
    output logic [31:0]           tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int PTR_W = $clog2(FRAME_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef HFT_TX_SEQ_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_next;
    logic [2:0]       idx, idx_next;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             handshake, pop, push, drop;
    logic [31:0]      word;

    logic [1:0]  act_mem   [FRAME_DEPTH];
    logic [31:0] price_mem [FRAME_DEPTH];
    logic [31:0] qty_mem   [FRAME_DEPTH];
    logic        idle_mem  [FRAME_DEPTH];
    logic        rdy_mem   [FRAME_DEPTH];
`ifdef HFT_TX_SEQ_EN
    logic [31:0] seq_mem   [FRAME_DEPTH];
    logic [31:0] seq_cnt;
`endif

    assign handshake = tx_valid & tx_ready;
    assign pop       = handshake && (idx == LAST_IDX);
    // A full buffer still accepts when the head leaves on this same edge.
    assign push      = res_done && ((count < CNT_W'(FRAME_DEPTH)) || pop);
    assign drop      = res_done && !push;

    // Frame storage: payload only, no reset needed
    always_ff @(posedge ap_clk) begin
        if (push) begin
            act_mem[wr_ptr]   <= res_action;
            price_mem[wr_ptr] <= res_price;
            qty_mem[wr_ptr]   <= res_quantity;
            idle_mem[wr_ptr]  <= res_idle;
            rdy_mem[wr_ptr]   <= res_ready;
`ifdef HFT_TX_SEQ_EN
            seq_mem[wr_ptr]   <= seq_cnt;
`endif
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            idx        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            overflow <= drop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
            if (drop && (drop_count != '1))
                drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

`ifdef HFT_TX_SEQ_EN
    // Every capture attempt consumes a number so the host can see drops as gaps.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            seq_cnt <= '0;
        else if (res_done)
            seq_cnt <= seq_cnt + 32'd1;
    end
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ((count > CNT_W'(1)) || push) ? SEND : IDLE;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        word = '0;
`ifdef HFT_TX_SEQ_EN
        case (idx)
            3'd0: word = seq_mem[rd_ptr];
            3'd1: word = {30'b0, act_mem[rd_ptr]};
            3'd2: word = price_mem[rd_ptr];
            3'd3: word = qty_mem[rd_ptr];
            3'd4: word = 32'd1;
            3'd5: word = {31'b0, idle_mem[rd_ptr]};
            3'd6: word = {31'b0, rdy_mem[rd_ptr]};
            default: word = '0;
        endcase
`else
        case (idx)
            3'd0: word = {30'b0, act_mem[rd_ptr]};
            3'd1: word = price_mem[rd_ptr];
            3'd2: word = qty_mem[rd_ptr];
            3'd3: word = 32'd1;
            3'd4: word = {31'b0, idle_mem[rd_ptr]};
            3'd5: word = {31'b0, rdy_mem[rd_ptr]};
            default: word = '0;
        endcase
`endif
    end

    assign tx_valid = (state == SEND);
    assign tx_last  = tx_valid && (idx == LAST_IDX);
    assign tx_data  = tx_valid ? word : '0;
    assign busy     = (count != '0);

endmodule

// File: tb/tb_hft_result_tx.sv
// Directed self-checking bench for hft_result_tx; follows HFT_TX_SEQ_EN when defined.
module tb_hft_result_tx;

    localparam int FRAME_DEPTH = 4;
    localparam int DROP_CNT_W  = 16;
`ifdef HFT_TX_SEQ_EN
    localparam int WPF = 7;
`else
    localparam int WPF = 6;
`endif

    logic                  ap_clk = 1'b0;
    logic                  ap_rst = 1'b0;
    logic                  res_done = 1'b0;
    logic [1:0]            res_action = '0;
    logic [31:0]           res_price = '0;
    logic [31:0]           res_quantity = '0;
    logic                  res_idle = 1'b0;
    logic                  res_ready = 1'b0;
    logic [31:0]           tx_data;
    logic                  tx_valid;
    logic                  tx_ready = 1'b0;
    logic                  tx_last;
    logic                  busy;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;

    hft_result_tx #(.FRAME_DEPTH(FRAME_DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .res_done(res_done), .res_action(res_action),
        .res_price(res_price), .res_quantity(res_quantity), .res_idle(res_idle),
        .res_ready(res_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 ap_clk = ~ap_clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rx_q[$];
    logic        rx_last_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_seq = '0;
    int          gap_err, stable_err, timeout_err;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_model();
        rx_q.delete();
        rx_last_q.delete();
        exp_q.delete();
        gap_err = 0;
        stable_err = 0;
        timeout_err = 0;
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [31:0] p, input logic [31:0] q,
                            input logic i, input logic r);
`ifdef HFT_TX_SEQ_EN
        exp_q.push_back(exp_seq);
`endif
        exp_q.push_back({30'b0, a});
        exp_q.push_back(p);
        exp_q.push_back(q);
        exp_q.push_back(32'd1);
        exp_q.push_back({31'b0, i});
        exp_q.push_back({31'b0, r});
        exp_seq = exp_seq + 32'd1;
    endtask

    task automatic set_frame(input logic [1:0] a, input logic [31:0] p, input logic [31:0] q,
                             input logic i, input logic r);
        res_action = a;
        res_price = p;
        res_quantity = q;
        res_idle = i;
        res_ready = r;
    endtask

    // Collects n accepted words; bp selects the 1,0,0,1 ready pattern.
    task automatic recv(input int n, input bit bp);
        int got = 0;
        int cyc = 0;
        int first = -1;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [31:0] pd = '0;
        while (got < n && cyc < 400) begin
            tx_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (pv && !pr && (!tx_valid || tx_data !== pd || tx_last !== pl)) stable_err++;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                rx_last_q.push_back(tx_last);
                if (first < 0) first = cyc;
                else if (!bp && cyc != first + got) gap_err++;
                got++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
            step();
            cyc++;
        end
        if (got < n) timeout_err++;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b0;
        #2 ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last: got %b expected 0", tx_last); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_seq = '0;
        step();
    endtask

    task automatic test_single();
        clear_model();
        tx_ready = 1'b1;
        set_frame(2'd2, 32'd10050, 32'd100, 1'b1, 1'b0);
        res_done = 1'b1;
        push_exp(2'd2, 32'd10050, 32'd100, 1'b1, 1'b0);
        step();
        res_done = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        recv(WPF, 1'b0);
        checks++; if (timeout_err != 0) begin errors++; $display("FAIL single_timeout: got %0d words expected %0d", rx_q.size(), WPF); end
        checks++; if (gap_err != 0) begin errors++; $display("FAIL single_gap: got %0d gaps expected 0", gap_err); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
            checks++; if (rx_last_q[k] !== (k == WPF - 1)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, rx_last_q[k], k == WPF - 1); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b expected 0", tx_valid); end
    endtask

    task automatic test_backpressure();
        clear_model();
        set_frame(2'd1, 32'hDEAD_BEEF, 32'd7, 1'b0, 1'b1);
        res_done = 1'b1;
        push_exp(2'd1, 32'hDEAD_BEEF, 32'd7, 1'b0, 1'b1);
        step();
        res_done = 1'b0;
        recv(WPF, 1'b1);
        checks++; if (timeout_err != 0) begin errors++; $display("FAIL bp_timeout: got %0d words expected %0d", rx_q.size(), WPF); end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stable_err); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
            checks++; if (rx_last_q[k] !== (k == WPF - 1)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", k, rx_last_q[k], k == WPF - 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        clear_model();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p = 32'd100 * (i + 1);
            set_frame(2'd3, p, p + 32'd5, 1'b1, 1'b1);
            res_done = 1'b1;
            push_exp(2'd3, p, p + 32'd5, 1'b1, 1'b1);
            step();
        end
        res_done = 1'b0;
        recv(3 * WPF, 1'b0);
        checks++; if (timeout_err != 0) begin errors++; $display("FAIL b2b_timeout: got %0d words expected %0d", rx_q.size(), 3 * WPF); end
        checks++; if (gap_err != 0) begin errors++; $display("FAIL b2b_gap: got %0d bubbles expected 0", gap_err); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
            checks++; if (rx_last_q[k] !== ((k % WPF) == WPF - 1)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", k, rx_last_q[k], (k % WPF) == WPF - 1); end
        end
    endtask

    task automatic test_overflow();
        int ov = 0;
        logic [31:0] iv;
        clear_model();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iv = i;
            set_frame(iv[1:0], 32'd1000 + iv, iv, iv[0], ~iv[0]);
            res_done = 1'b1;
            if (i < 4) push_exp(iv[1:0], 32'd1000 + iv, iv, iv[0], ~iv[0]);
            step();
            if (overflow === 1'b1) ov++;
        end
        res_done = 1'b0;
        exp_seq = exp_seq + 32'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            if (overflow === 1'b1) ov++;
        end
        checks++; if (ov != 2) begin errors++; $display("FAIL ovf_pulses: got %0d expected 2", ov); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", busy); end
        recv(4 * WPF, 1'b0);
        checks++; if (timeout_err != 0) begin errors++; $display("FAIL ovf_timeout: got %0d words expected %0d", rx_q.size(), 4 * WPF); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
        end
        tx_ready = 1'b1;
        step();
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_extra_frame: tx_valid got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_after: got %b expected 0", busy); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        int ov = 0;
        int cyc = 0;
        bit sent = 1'b0;
        logic [31:0] iv;
        clear_model();
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            iv = i;
            set_frame(iv[1:0], iv, iv + 32'd50, 1'b0, 1'b1);
            res_done = 1'b1;
            push_exp(iv[1:0], iv, iv + 32'd50, 1'b0, 1'b1);
            step();
        end
        res_done = 1'b0;
        step();
        while (rx_q.size() < WPF && cyc < 40) begin
            tx_ready = 1'b1;
            if (tx_valid && tx_last && !sent) begin
                set_frame(2'd1, 32'd5, 32'd55, 1'b1, 1'b0);
                res_done = 1'b1;
                push_exp(2'd1, 32'd5, 32'd55, 1'b1, 1'b0);
                sent = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                rx_last_q.push_back(tx_last);
            end
            step();
            res_done = 1'b0;
            if (overflow === 1'b1) ov++;
            cyc++;
        end
        checks++; if (sent !== 1'b1) begin errors++; $display("FAIL fullpop_no_last: got %b expected 1", sent); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL fullpop_valid: got %b expected 1", tx_valid); end
        recv(4 * WPF, 1'b0);
        checks++; if (ov != 0) begin errors++; $display("FAIL fullpop_overflow: got %0d expected 0", ov); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL fullpop_drop_count: got %0d expected 2", drop_count); end
        checks++; if (timeout_err != 0 || rx_q.size() != 5 * WPF) begin errors++; $display("FAIL fullpop_words: got %0d expected %0d", rx_q.size(), 5 * WPF); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL fullpop_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int cyc = 0;
        clear_model();
        tx_ready = 1'b0;
        set_frame(2'd3, 32'd77, 32'd88, 1'b1, 1'b1);
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        while (acc < 3 && cyc < 30) begin
            tx_ready = 1'b1;
            if (tx_valid) acc++;
            step();
            cyc++;
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got %b expected 1", tx_valid); end
        #2 ap_rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL mid_data: got %h expected 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL mid_drop_count: got %0d expected 0", drop_count); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_seq = '0;
        step();
        set_frame(2'd1, 32'd555, 32'd9, 1'b0, 1'b0);
        res_done = 1'b1;
        push_exp(2'd1, 32'd555, 32'd9, 1'b0, 1'b0);
        step();
        res_done = 1'b0;
        recv(WPF, 1'b0);
        checks++; if (timeout_err != 0) begin errors++; $display("FAIL mid_timeout: got %0d words expected %0d", rx_q.size(), WPF); end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL mid_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
